dspl_capture_nexysa7: RTL and testbench
=======================================

// Module: dspl_capture_NexysA7
// PURPOSE
// - Receive end of the 8-digit Nexys A7 seven-segment scan bus: samples an/dec_cat as produced by
//   dspl_drv_NexysA7 and rebuilds the eight 6-bit digit codes {en, hex[3:0], dp} (d1..d8 format).
// - Used for loopback self-check of display paths and for feeding displayed values back into logic.
// PARAMETERS
// - SETTLE   4       consecutive identical samples of an/dec_cat required before a digit is accepted
// - TIMEOUT  200000  cycles with no accepted digit before all outputs are force-blanked
// PORTS
// - clk        in   1   system clock
// - rst        in   1   synchronous reset, active-high
// - an         in   8   anode enables, active-low; an[7] = d1 (leftmost) ... an[0] = d8
// - dec_cat    in   8   {a,b,c,d,e,f,g,dp}, active-low
// - d1..d8     out  6   captured digit codes {en, hex[3:0], dp}
// - frame_vld  out  1   one-cycle pulse when d1..d8 update
// - blank      out  1   high while in timeout state (no scan activity)
// - seg_err    out  1   sticky: undecodable segment pattern seen (see CONFIGURATION)
// BEHAVIOUR
// - Reset: d1..d8 = 6'b0, frame_vld = 0, blank = 1, seg_err = 0, seen mask = 0, counters = 0.
// - Inputs registered once (sample stage); all decisions use the registered copy.
// - Sample is a candidate only if ~an is one-hot; zero or multiple anodes low -> settle count cleared.
// - Settle counter increments while candidate equals previous sample, restarts at 1 on any change;
//   digit accepted on the cycle the count reaches SETTLE (once per dwell, no re-accept until change).
// - Accept: index = position of low anode; hex = seg7_to_hex(~dec_cat[7:1]); dp = ~dec_cat[0];
//   written into shadow[index] with en = 1; seen[index] set. Latency sample->shadow: SETTLE+1 cycles.
// - Frame close: accept whose index is already in seen -> d1..d8 <= shadow (en = 0, hex/dp = 0 for
//   unseen slots), frame_vld pulses next cycle, seen <= only the new index, shadow restarts with it.
// - Same-index re-accept after change (e.g. value change on a single-digit scan) also closes a frame.
// - Timeout counter cleared on every accept; at TIMEOUT: d1..d8 <= 0, blank = 1, seen <= 0,
//   frame_vld pulses once; stays blank (no further pulses) until next accept, which clears blank.
// - Accept and timeout in same cycle: accept wins, counter cleared.
// - Counter widths: settle $clog2(SETTLE+1), timeout $clog2(TIMEOUT+1); both saturate, never wrap.
// - rst mid-frame: shadow and seen discarded, outputs return to reset values on next edge.
// - Hex decode: standard 16 glyphs (A,b,C,d,E,F for 10..15); all-segments-off = blank digit (en = 0).
// CONFIGURATION
// - DSPL_CAP_ERR_EN defined: non-glyph pattern sets seg_err (sticky until rst) and the digit is
//   stored with en = 0, hex = 0; still counts as seen.
// - Not defined: seg_err tied 0; non-glyph pattern stored as en = 1, hex = 4'hF.
// STRUCTURE
// - Package dspl_pkg: digit_t {en, hex, dp}, NUM_DIGITS = 8, SEG_* glyph localparams for 0..F and
//   SEG_BLANK; shared with the driver side.
// - Sub-module seg7_to_hex: combinational 7-bit pattern -> {valid, blank, hex[3:0]}.
// - Top: sample regs, settle/timeout counters, shadow + seen registers, frame-close logic.
// TESTING
// - Drive dspl_drv_NexysA7 with d1..d8 = {1,0x1,0}..{1,0x8,0} -> after 2nd frame d1..d8 match, one
//   frame_vld per scan, blank = 0.
// - Driver d3/d4 disabled (en = 0) -> d3 = d4 = 6'b0, others exact; dp set on d5 -> d5[0] = 1.
// - Glitch: an = 8'hFE held SETTLE-1 cycles then changed -> no accept, shadow unchanged.
// - Two anodes low (an = 8'hFC) held 50 cycles -> ignored, no frame_vld.
// - Scan stopped (an = 8'hFF) for TIMEOUT cycles -> d1..d8 = 0, blank = 1, single frame_vld;
//   scan resumes -> blank clears on first accept.
// - dec_cat = 8'b0101_0101 on digit 0: ERR_EN -> seg_err = 1, d8 en = 0; else d8 = {1,0xF,0};
//   rst mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dspl_pkg.sv
// -----------------------------------------------------------------------------
// dspl_pkg
// Shared types and constants for the 8-digit seven-segment display path
// (driver and capture sides).
//   digit_t     : {en, hex[3:0], dp}, one display digit
//   seg_dec_t   : result of a segment-pattern decode {valid, blank, hex[3:0]}
//   cap_state_t : capture-side activity state (blanked / scanning)
//   SEG_*       : active-high {a,b,c,d,e,f,g} glyphs for 0..F plus SEG_BLANK
// -----------------------------------------------------------------------------
package dspl_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef struct packed {
    logic       en;
    logic [3:0] hex;
    logic       dp;
  } digit_t;

  typedef struct packed {
    logic       valid;  // pattern is one of the 16 glyphs or all-off
    logic       blank;  // all segments off
    logic [3:0] hex;
  } seg_dec_t;

  typedef enum logic {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } cap_state_t;

  // Segment order {a,b,c,d,e,f,g}, 1 = segment lit.
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] one;
    one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

  // Bit position of the (single) set bit; only meaningful when is_onehot(v).
  function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_DIGITS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
// Combinational decode of an active-high {a,b,c,d,e,f,g} segment pattern back
// to a hex nibble.
//   seg  in  7  segment pattern, 1 = lit
//   dec  out    {valid, blank, hex}; valid = glyph or all-off, blank = all-off
// -----------------------------------------------------------------------------
module seg7_to_hex
  import dspl_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  always_comb begin
    dec.valid = 1'b1;
    dec.blank = 1'b0;
    dec.hex   = 4'h0;
    case (seg)
      SEG_0:     dec.hex = 4'h0;
      SEG_1:     dec.hex = 4'h1;
      SEG_2:     dec.hex = 4'h2;
      SEG_3:     dec.hex = 4'h3;
      SEG_4:     dec.hex = 4'h4;
      SEG_5:     dec.hex = 4'h5;
      SEG_6:     dec.hex = 4'h6;
      SEG_7:     dec.hex = 4'h7;
      SEG_8:     dec.hex = 4'h8;
      SEG_9:     dec.hex = 4'h9;
      SEG_A:     dec.hex = 4'hA;
      SEG_B:     dec.hex = 4'hB;
      SEG_C:     dec.hex = 4'hC;
      SEG_D:     dec.hex = 4'hD;
      SEG_E:     dec.hex = 4'hE;
      SEG_F:     dec.hex = 4'hF;
      SEG_BLANK: dec.blank = 1'b1;
      default:   dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/dspl_capture_nexysa7.sv
// -----------------------------------------------------------------------------
// dspl_capture_nexysa7
// Receive side of the multiplexed 8-digit Nexys A7 seven-segment bus. Watches
// the anode/cathode scan, waits for each digit to settle, decodes it and
// rebuilds the eight {en, hex, dp} digit codes. A frame is published whenever
// a digit position repeats; a long silence blanks everything.
//
// Parameters
//   SETTLE   identical consecutive samples needed before a digit is accepted
//   TIMEOUT  cycles without an accepted digit before outputs are blanked
// Ports
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   an         in   8  anodes, active-low; an[7] = d1 (leftmost) .. an[0] = d8
//   dec_cat    in   8  {a,b,c,d,e,f,g,dp}, active-low
//   d1..d8     out  6  captured digits {en, hex[3:0], dp}
//   frame_vld  out  1  one-cycle pulse coincident with a d1..d8 update
//   blank      out  1  high while no scan activity (timeout state)
//   seg_err    out  1  sticky undecodable-pattern flag
// Build option
//   DSPL_CAP_ERR_EN  when defined, a non-glyph pattern raises seg_err and is
//                    stored as en = 0, hex = 0; otherwise it is stored as
//                    en = 1, hex = F and seg_err stays 0.
// -----------------------------------------------------------------------------
module dspl_capture_nexysa7
  import dspl_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] an,
  input  logic [7:0] dec_cat,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       frame_vld,
  output logic       blank,
  output logic       seg_err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);

  // Sample stage and the sample before it.
  logic [7:0]            an_q, an_d;
  logic [7:0]            cat_q, cat_d;
  logic [7:0]            prev_an_q, prev_an_d;
  logic [7:0]            prev_cat_q, prev_cat_d;

  logic [SW-1:0]         settle_q, settle_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  digit_t                disp_q   [NUM_DIGITS];
  digit_t                disp_d   [NUM_DIGITS];
  digit_t                frame_view [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] seen_q, seen_d;
  logic                  frame_vld_q, frame_vld_d;
  cap_state_t            state_q, state_d;

  logic [7:0]            an_low;
  logic                  candidate;
  logic                  same_sample;
  logic                  accept;
  logic [IDX_W-1:0]      acc_idx;
  logic [6:0]            seg_pat;
  seg_dec_t              seg_dec;
  digit_t                acc_digit;

`ifdef DSPL_CAP_ERR_EN
  logic                  seg_err_q, seg_err_d;
  logic                  acc_bad;
`endif

  // ---------------------------------------------------------------------------
  // Sample stage: everything downstream only looks at registered copies.
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d       = an;
    cat_d      = dec_cat;
    prev_an_d  = an_q;
    prev_cat_d = cat_q;
  end

  // ---------------------------------------------------------------------------
  // Settle counter. A non-candidate sample (no anode or several anodes low)
  // clears it; a changed candidate restarts at 1. Saturating at SETTLE means
  // the "reaches SETTLE" condition fires once per dwell.
  // ---------------------------------------------------------------------------
  always_comb begin
    an_low      = ~an_q;
    candidate   = is_onehot(an_low);
    same_sample = (an_q == prev_an_q) && (cat_q == prev_cat_q);
    settle_d    = '0;
    accept      = 1'b0;
    if (candidate) begin
      if (!same_sample) begin
        settle_d = SW'(1);
        accept   = (SETTLE_MAX == SW'(1));
      end else if (settle_q != SETTLE_MAX) begin
        settle_d = settle_q + SW'(1);
        accept   = (settle_d == SETTLE_MAX);
      end else begin
        settle_d = settle_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit decode of the current sample.
  // ---------------------------------------------------------------------------
  assign seg_pat = ~cat_q[7:1];

  seg7_to_hex u_seg7_to_hex (
    .seg (seg_pat),
    .dec (seg_dec)
  );

  always_comb begin
    acc_idx       = onehot_index(an_low);
    acc_digit.dp  = ~cat_q[0];
    acc_digit.en  = 1'b0;
    acc_digit.hex = 4'h0;
`ifdef DSPL_CAP_ERR_EN
    acc_bad       = 1'b0;
`endif
    if (seg_dec.blank) begin
      acc_digit.en  = 1'b0;
    end else if (seg_dec.valid) begin
      acc_digit.en  = 1'b1;
      acc_digit.hex = seg_dec.hex;
    end else begin
`ifdef DSPL_CAP_ERR_EN
      acc_bad       = 1'b1;
`else
      acc_digit.en  = 1'b1;
      acc_digit.hex = 4'hF;
`endif
    end
  end

  // Published view of the shadow: slots not written this frame read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_view
      assign frame_view[gi] = seen_q[gi] ? shadow_q[gi] : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Frame assembly, timeout and activity state (next-state logic).
  // ---------------------------------------------------------------------------
  always_comb begin
    shadow_d    = shadow_q;
    disp_d      = disp_q;
    seen_d      = seen_q;
    frame_vld_d = 1'b0;
    state_d     = state_q;
    tmo_d       = tmo_q;
`ifdef DSPL_CAP_ERR_EN
    seg_err_d   = seg_err_q;
`endif
    if (accept) begin
      // Accept wins over a simultaneous timeout.
      tmo_d   = '0;
      state_d = ST_ACTIVE;
      // A position seen twice means the scan wrapped: publish and restart.
      if (seen_q[acc_idx]) begin
        disp_d      = frame_view;
        frame_vld_d = 1'b1;
        seen_d      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          shadow_d[i] = '0;
        end
      end
      seen_d[acc_idx]   = 1'b1;
      shadow_d[acc_idx] = acc_digit;
`ifdef DSPL_CAP_ERR_EN
      if (acc_bad) seg_err_d = 1'b1;
`endif
    end else if (tmo_q != TIMEOUT_MAX) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_d == TIMEOUT_MAX) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          disp_d[i] = '0;
        end
        seen_d      = '0;
        state_d     = ST_BLANK;
        // Only announce the transition into blank, not a repeat of it.
        frame_vld_d = (state_q == ST_ACTIVE);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= 8'hFF;
      cat_q       <= 8'hFF;
      prev_an_q   <= 8'hFF;
      prev_cat_q  <= 8'hFF;
      settle_q    <= '0;
      tmo_q       <= '0;
      seen_q      <= '0;
      frame_vld_q <= 1'b0;
      state_q     <= ST_BLANK;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
`ifdef DSPL_CAP_ERR_EN
      seg_err_q   <= 1'b0;
`endif
    end else begin
      an_q        <= an_d;
      cat_q       <= cat_d;
      prev_an_q   <= prev_an_d;
      prev_cat_q  <= prev_cat_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      seen_q      <= seen_d;
      frame_vld_q <= frame_vld_d;
      state_q     <= state_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= shadow_d[i];
        disp_q[i]   <= disp_d[i];
      end
`ifdef DSPL_CAP_ERR_EN
      seg_err_q   <= seg_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: slot 7 is the leftmost digit d1.
  // ---------------------------------------------------------------------------
  assign d1        = disp_q[7];
  assign d2        = disp_q[6];
  assign d3        = disp_q[5];
  assign d4        = disp_q[4];
  assign d5        = disp_q[3];
  assign d6        = disp_q[2];
  assign d7        = disp_q[1];
  assign d8        = disp_q[0];
  assign frame_vld = frame_vld_q;
  assign blank     = (state_q == ST_BLANK);
`ifdef DSPL_CAP_ERR_EN
  assign seg_err   = seg_err_q;
`else
  assign seg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dspl_capture_nexysa7.sv
// -----------------------------------------------------------------------------
// Bench for dspl_capture_nexysa7. Stimulus emulates the scanning driver one
// dwell at a time; a digit-level model predicts each published frame and
// pushes it to a queue, and a monitor compares every frame_vld against it.
// -----------------------------------------------------------------------------
module tb_dspl_capture_nexysa7;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] an;
  logic [7:0] dec_cat;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       frame_vld;
  logic       blank;
  logic       seg_err;

  always #5 clk = ~clk;

  dspl_capture_nexysa7 #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .an        (an),
    .dec_cat   (dec_cat),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .d7        (d7),
    .d8        (d8),
    .frame_vld (frame_vld),
    .blank     (blank),
    .seg_err   (seg_err)
  );

  typedef struct packed {
    logic        blank;
    logic [47:0] digs;   // slot i at [6*i +: 6]; slot 7 = d1
  } frame_t;

  int     errors = 0;
  int     checks = 0;
  frame_t exp_q [$];

  // Standard glyphs, {a,b,c,d,e,f,g} active-high, for 0..F.
  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model state: digits written since the last publish.
  logic [5:0] m_shadow [8];
  logic [7:0] m_seen   = '0;
  logic       m_active = 1'b0;
  logic       m_seg_err = 1'b0;
  logic [7:0] last_an  = 8'hFF;
  logic [7:0] last_cat = 8'hFF;
  int         idle     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic is_glyph(input logic [6:0] s);
    for (int h = 0; h < 16; h++) if (glyph[h] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [5:0] exp_code(input logic [6:0] s, input logic dp);
    if (s == 7'h00) return {1'b0, 4'h0, dp};
    for (int h = 0; h < 16; h++) if (glyph[h] == s) return {1'b1, 4'(h), dp};
`ifdef DSPL_CAP_ERR_EN
    return {1'b0, 4'h0, dp};
`else
    return {1'b1, 4'hF, dp};
`endif
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] s;
    do s = 7'($urandom); while (s == 7'h00 || is_glyph(s));
    return s;
  endfunction

  // Hold one bus value; identical back-to-back values get a one-cycle gap so
  // they remain distinct dwells. Called and returns on a negedge.
  task automatic drive(input logic [7:0] a, input logic [7:0] c, input int len);
    if (a == last_an && c == last_cat) begin
      an = 8'hFF; dec_cat = 8'hFF; last_an = 8'hFF; last_cat = 8'hFF;
      @(negedge clk);
      idle++;
    end
    an = a; dec_cat = c; last_an = a; last_cat = c;
    repeat (len) @(negedge clk);
    idle += len;
  endtask

  // One digit dwell on anode slot (0 = d8 .. 7 = d1); long enough dwells are
  // accepted and run through the frame rules before the bus is driven.
  task automatic dig(input int slot, input logic [6:0] seg, input logic dp, input int len);
    logic [7:0] a;
    frame_t     f;
    a = ~(8'h01 << slot);
    if (len >= SETTLE) begin
      if (m_seen[slot]) begin
        f.blank = 1'b0;
        for (int i = 0; i < 8; i++) f.digs[6*i +: 6] = m_seen[i] ? m_shadow[i] : 6'h00;
        exp_q.push_back(f);
        m_seen = '0;
      end
      m_shadow[slot] = exp_code(seg, dp);
      m_seen[slot]   = 1'b1;
      m_active       = 1'b1;
`ifdef DSPL_CAP_ERR_EN
      if (seg != 7'h00 && !is_glyph(seg)) m_seg_err = 1'b1;
`endif
      idle = 0;
    end
    drive(a, {~seg, ~dp}, len);
  endtask

  task automatic model_timeout();
    frame_t f;
    if (m_active) begin
      f.blank = 1'b1;
      f.digs  = '0;
      exp_q.push_back(f);
    end
    m_seen   = '0;
    m_active = 1'b0;
  endtask

  // Monitor: every published frame is compared with the next prediction.
  initial begin
    frame_t e;
    int     nframes;
    nframes = 0;
    forever begin
      @(negedge clk);
      if (frame_vld === 1'b1) begin
        nframes++;
        $display("frame %0d: d1..d8 = %h %h %h %h %h %h %h %h blank=%b",
                 nframes, d1, d2, d3, d4, d5, d6, d7, d8, blank);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got %h blank=%b expected no frame",
                   {d1, d2, d3, d4, d5, d6, d7, d8}, blank);
        end else begin
          e = exp_q.pop_front();
          check("frame", {15'h0, blank, d1, d2, d3, d4, d5, d6, d7, d8}, {15'h0, e});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; an = 8'hFF; dec_cat = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 64'h0);
    check("rst_frame_vld", frame_vld, 64'h0);
    check("rst_blank", blank, 64'h1);
    check("rst_seg_err", seg_err, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Two scans of 1..8 on d1..d8; the second scan publishes the first.
    for (int s = 0; s < 2; s++)
      for (int k = 1; k <= 8; k++) dig(8 - k, glyph[k], 1'b0, 10);
    check("blank_after_accept", blank, 64'h0);

    // d3/d4 dark, dp on d5.
    for (int k = 1; k <= 8; k++)
      dig(8 - k, (k == 3 || k == 4) ? 7'h00 : glyph[k], (k == 5), 10);

    // Short glitch on d8 and a two-anode pattern: neither may be accepted.
    drive(8'hFE, {~glyph[9], 1'b1}, SETTLE - 1);
    drive(8'hFC, {~glyph[3], 1'b1}, 50);
    for (int k = 1; k <= 8; k++) dig(8 - k, glyph[k + 7], 1'b0, 10);

    // Undecodable pattern on d8 (dec_cat = 0101_0101), then a scan to publish it.
    for (int k = 1; k <= 7; k++) dig(8 - k, glyph[k], 1'b0, 10);
    dig(0, 7'b1010101, 1'b0, 10);
    for (int k = 1; k <= 8; k++) dig(8 - k, glyph[16 - k], 1'b1, 10);
    check("seg_err_directed", seg_err, {63'h0, m_seg_err});

    // Randomised dwells: mostly in scan order, some random, glitches, multi-anode.
    begin
      int scan_pos;
      scan_pos = 7;
      for (int n = 0; n < 300; n++) begin
        int         r, slot, k;
        logic [6:0] s;
        logic [7:0] a;
        r = $urandom_range(0, 9);
        if (r == 0 && idle < TIMEOUT - 60) begin
          dig($urandom_range(0, 7), glyph[$urandom_range(0, 15)], 1'($urandom),
              $urandom_range(1, SETTLE - 1));
        end else if (r == 1 && idle < TIMEOUT - 120) begin
          do a = 8'($urandom); while ($countones(~a) < 2);
          drive(a, 8'($urandom), $urandom_range(5, 50));
        end else begin
          if ($urandom_range(0, 9) < 7) begin
            slot = scan_pos;
            scan_pos = (scan_pos == 0) ? 7 : scan_pos - 1;
          end else begin
            slot = $urandom_range(0, 7);
          end
          k = $urandom_range(0, 15);
          if (k < 12)       s = glyph[$urandom_range(0, 15)];
          else if (k < 14)  s = 7'h00;
          else if (k == 14) s = rand_bad();
          else              s = glyph[15];
          dig(slot, s, 1'($urandom), $urandom_range(SETTLE, SETTLE + 12));
        end
      end
    end
    drive(8'hFF, 8'hFF, 20);
    check("seg_err_random", seg_err, {63'h0, m_seg_err});

    // Reset part-way through a frame: everything returns to reset values.
    dig(7, glyph[2], 1'b0, 10);
    dig(6, glyph[4], 1'b1, 10);
    dig(5, glyph[6], 1'b0, 6);
    rst = 1'b1; an = 8'hFF; dec_cat = 8'hFF; last_an = 8'hFF; last_cat = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    m_seen = '0; m_active = 1'b0; m_seg_err = 1'b0; idle = 0;
    check("midrst_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 64'h0);
    check("midrst_frame_vld", frame_vld, 64'h0);
    check("midrst_blank", blank, 64'h1);
    check("midrst_seg_err", seg_err, 64'h0);

    // Fresh scans after reset; only the new digits may appear.
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 8; k++) dig(7 - k, glyph[(k * 3 + s) % 16], 1'(k & 1), 9);

    // Scan stops: outputs blank with a single pulse, then recover.
    model_timeout();
    drive(8'hFF, 8'hFF, TIMEOUT + SETTLE + 20);
    check("timeout_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 64'h0);
    check("timeout_blank", blank, 64'h1);
    dig(7, glyph[5], 1'b0, 10);
    check("resume_blank", blank, 64'h0);
    dig(6, glyph[6], 1'b0, 10);
    dig(7, glyph[7], 1'b0, 10);
    drive(8'hFF, 8'hFF, 20);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
